branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter NR_BTB_ENTRIES, default 16, meaning direct-mapped BTB depth (power of 2).
REQ-002 SHALL have parameter NR_BHT_ENTRIES, default 64, meaning 2-bit counter table depth (power of 2).
REQ-003 SHALL have ports, reset rstn synchronous active-low, clock clk:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  fetch presents an instruction
req_pc  in  64  instruction PC
req_id  in  id_t  instruction sequence number
req_is_branch  in  1  predecoded control-flow (cond, JAL, JALR)
req_is_jump  in  1  predecoded unconditional (JAL/JALR)
req_ready  out  1  request accepted this cycle
pred_valid  out  1  prediction delivered to fetch
pred_taken  out  1  predicted direction
pred_pcnext  out  64  predicted next PC
bq_push_valid  out  1  push to branch queue
bq_push_ready  in  1  branch queue not full
bq_push_bqid  in  bq_id_t  BQ slot allocated for the push
bq_push_pc  out  64  branch PC
bq_push_id  out  id_t  branch sequence number
bq_push_bp  out  bp_t  {taken, pcnext} prediction
pred_bqid  out  bq_id_t  BQ slot of delivered branch
upd_valid  in  1  commit pops a BQ entry
upd_pc  in  64  committed branch PC
upd_taken  in  1  resolved direction
upd_target  in  64  resolved target
upd_missprediction  in  1  entry was mispredicted
squash_valid  in  1  pipeline flush
perf_mispred_cnt  out  32  committed mispredictions

Function
REQ-004 SHALL hold one stage register S1 {valid, pc, id, is_branch, taken, pcnext}; latency request->pred_valid = 1 cycle minimum.
REQ-005 SHALL define s1_fire = S1.valid && (!S1.is_branch || bq_push_ready) && !squash_valid.
REQ-006 SHALL drive req_ready = !squash_valid && (!S1.valid || s1_fire); accept = req_valid && req_ready loads S1.
REQ-007 SHALL hold S1 unchanged while S1.valid && !s1_fire (BQ full backpressure).
REQ-008 SHALL drive bq_push_valid = S1.valid && S1.is_branch && !squash_valid; bq_push_pc/id/bp from S1; pred_bqid = bq_push_bqid.
REQ-009 SHALL drive pred_valid = s1_fire; pred_taken/pred_pcnext from S1; non-branches SHALL predict taken=0, pcnext=pc+4 and never push.
REQ-010 SHALL index BTB with pc[$clog2(NR_BTB_ENTRIES)+1:2], tag pc[21+... fixed 16 bits pc[$clog2(NR_BTB_ENTRIES)+17:$clog2(NR_BTB_ENTRIES)+2]; hit = valid && tag match.
REQ-011 SHALL index BHT with pc[$clog2(NR_BHT_ENTRIES)+1:2].
REQ-012 SHALL compute at accept: taken = is_branch && btb_hit && (is_jump || bht[1]); pcnext = taken ? btb_target : pc+4 (64-bit wrap).
REQ-013 SHALL, on upd_valid, update BHT saturating: taken -> min(c+1,3), not taken -> max(c-1,0).
REQ-014 SHALL, on upd_valid && upd_taken, write BTB entry {valid=1, tag, target=upd_target}; not-taken updates SHALL leave BTB unchanged.
REQ-015 SHALL read old table contents when lookup and update hit the same index in one cycle (no bypass); update visible from next cycle.
REQ-016 SHALL, on squash_valid, clear S1.valid next cycle, accept nothing, push nothing; tables and updates unaffected (simultaneous upd_valid still applied).
REQ-017 SHALL increment perf_mispred_cnt on upd_valid && upd_missprediction, saturating at 0xFFFFFFFF.

Reset
REQ-018 SHALL on rstn low: S1.valid=0, all BTB valid=0, all BHT counters=2'b01, perf_mispred_cnt=0; outputs req_ready=1, pred_valid=0, bq_push_valid=0 after reset.
REQ-019 SHALL abandon any held S1 entry on reset mid-backpressure; no push after rstn rises.

Verification
REQ-020 Reset, request pc=0x1000 branch -> next cycle pred_taken=0, pcnext=0x1004, bq_push_valid=1.
REQ-021 Two upd_valid pc=0x1000 taken target=0x2000, then request pc=0x1000 -> pred_taken=1, pcnext=0x2000 (counter 01->10->11).
REQ-022 bq_push_ready=0 for 3 cycles with branch in S1 -> req_ready=0, S1 held, pred_valid=0; ready=1 -> single push, pred_valid=1.
REQ-023 squash_valid while S1 holds branch under backpressure -> no push, pred_valid=0 next cycle, req_ready=1 cycle after.
REQ-024 Lookup and update same index same cycle -> prediction uses pre-update counter; next lookup uses updated value.
REQ-025 Counter at 0xFFFFFFFE, two mispredicted updates -> 0xFFFFFFFF and stays.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Single-stage front-end branch predictor.
//
// A direct-mapped BTB (valid, 16-bit tag, 64-bit target) and a table of
// 2-bit saturating direction counters are read when fetch presents an
// instruction. The prediction is held in one stage register (_p1). From that
// register it is delivered to fetch, and control-flow instructions are also
// pushed into the branch queue. Committed branches train both tables. A
// saturating counter tracks committed mispredictions.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/pc/id            instruction presented by fetch
//   req_is_branch/is_jump      predecode: any control flow / unconditional
//   req_ready                  request accepted this cycle
//   pred_valid/taken/pcnext    prediction delivered to fetch
//   pred_bqid                  BQ slot of the delivered branch
//   bq_push_valid/ready        push handshake to the branch queue
//   bq_push_bqid               slot the BQ allocates for the push
//   bq_push_pc/id/bp           pushed branch PC, id, {taken, pcnext}
//   upd_valid/pc/taken/target  committed branch outcome (table training)
//   upd_missprediction         committed branch was mispredicted
//   squash_valid               pipeline flush
//   perf_mispred_cnt           committed mispredictions (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int NR_BTB_ENTRIES = 16,
  parameter int NR_BHT_ENTRIES = 64,
  parameter int ID_W           = 8,
  parameter int BQ_ID_W        = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  input  logic [63:0]        req_pc,
  input  logic [ID_W-1:0]    req_id,
  input  logic               req_is_branch,
  input  logic               req_is_jump,
  output logic               req_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [63:0]        pred_pcnext,
  output logic               bq_push_valid,
  input  logic               bq_push_ready,
  input  logic [BQ_ID_W-1:0] bq_push_bqid,
  output logic [63:0]        bq_push_pc,
  output logic [ID_W-1:0]    bq_push_id,
  output logic [64:0]        bq_push_bp,
  output logic [BQ_ID_W-1:0] pred_bqid,
  input  logic               upd_valid,
  input  logic [63:0]        upd_pc,
  input  logic               upd_taken,
  input  logic [63:0]        upd_target,
  input  logic               upd_missprediction,
  input  logic               squash_valid,
  output logic [31:0]        perf_mispred_cnt
);

  localparam int BTB_IW = $clog2(NR_BTB_ENTRIES);
  localparam int BHT_IW = $clog2(NR_BHT_ENTRIES);
  localparam int TAG_LO = BTB_IW + 2;
  localparam int TAG_HI = BTB_IW + 17;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Tables
  logic              btb_vld [NR_BTB_ENTRIES];
  logic [15:0]       btb_tag [NR_BTB_ENTRIES];
  logic [63:0]       btb_tgt [NR_BTB_ENTRIES];
  logic [1:0]        bht     [NR_BHT_ENTRIES];

  // Stage-1 register
  logic              vld_p1;
  logic              br_p1;
  logic              taken_p1;
  logic [63:0]       pc_p1;
  logic [63:0]       pcnext_p1;
  logic [ID_W-1:0]   id_p1;

  logic              s1_fire;
  logic              accept;

  // ---- stage 0: table lookup for the presented instruction ----
  logic [BTB_IW-1:0] req_btb_idx;
  logic [BHT_IW-1:0] req_bht_idx;
  logic [15:0]       req_tag;
  logic              btb_hit;
  logic              taken_p0;
  logic [63:0]       pcnext_p0;

  assign req_btb_idx = req_pc[BTB_IW+1:2];
  assign req_bht_idx = req_pc[BHT_IW+1:2];
  assign req_tag     = req_pc[TAG_HI:TAG_LO];
  assign btb_hit     = btb_vld[req_btb_idx] && (btb_tag[req_btb_idx] == req_tag);
  // Tables are written with non-blocking updates, so a same-cycle update to
  // the looked-up index is only seen by the following lookup.
  assign taken_p0    = req_is_branch && btb_hit && (req_is_jump || bht[req_bht_idx][1]);
  assign pcnext_p0   = taken_p0 ? btb_tgt[req_btb_idx] : req_pc + 64'd4;

  assign s1_fire   = vld_p1 && (!br_p1 || bq_push_ready) && !squash_valid;
  assign req_ready = !squash_valid && (!vld_p1 || s1_fire);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
    end else if (squash_valid) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (s1_fire) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      br_p1     <= req_is_branch;
      taken_p1  <= taken_p0;
      pc_p1     <= req_pc;
      pcnext_p1 <= pcnext_p0;
      id_p1     <= req_id;
    end
  end

  // ---- stage 1: deliver prediction and push to the branch queue ----
  assign pred_valid    = s1_fire;
  assign pred_taken    = taken_p1;
  assign pred_pcnext   = pcnext_p1;
  assign bq_push_valid = vld_p1 && br_p1 && !squash_valid;
  assign bq_push_pc    = pc_p1;
  assign bq_push_id    = id_p1;
  assign bq_push_bp    = {taken_p1, pcnext_p1};
  assign pred_bqid     = bq_push_bqid;

  // ---- commit-side training ----
  logic [BTB_IW-1:0] upd_btb_idx;
  logic [BHT_IW-1:0] upd_bht_idx;

  assign upd_btb_idx = upd_pc[BTB_IW+1:2];
  assign upd_bht_idx = upd_pc[BHT_IW+1:2];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NR_BTB_ENTRIES; i++) btb_vld[i] <= 1'b0;
      for (int i = 0; i < NR_BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      bht[upd_bht_idx] <= upd_taken ? ctr_inc(bht[upd_bht_idx]) : ctr_dec(bht[upd_bht_idx]);
      if (upd_taken) btb_vld[upd_btb_idx] <= 1'b1;
    end
  end

  // Tag/target are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rstn && upd_valid && upd_taken) begin
      btb_tag[upd_btb_idx] <= upd_pc[TAG_HI:TAG_LO];
      btb_tgt[upd_btb_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_mispred_cnt <= 32'd0;
    end else if (upd_valid && upd_missprediction) begin
      perf_mispred_cnt <= cnt_sat_inc(perf_mispred_cnt);
    end
  end

  // PC bits outside the index/tag fields do not affect training.
  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc[63:TAG_HI+1], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed-vector bench for branch_predictor with default table sizes
// (16-entry BTB: index pc[5:2], tag pc[21:6]; 64-entry BHT: index pc[7:2]).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well away from the clock edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic [63:0] req_pc;
  logic [7:0]  req_id;
  logic        req_is_branch;
  logic        req_is_jump;
  logic        req_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [63:0] pred_pcnext;
  logic        bq_push_valid;
  logic        bq_push_ready;
  logic [3:0]  bq_push_bqid;
  logic [63:0] bq_push_pc;
  logic [7:0]  bq_push_id;
  logic [64:0] bq_push_bp;
  logic [3:0]  pred_bqid;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_missprediction;
  logic        squash_valid;
  logic [31:0] perf_mispred_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk                (clk),
    .rstn               (rstn),
    .req_valid          (req_valid),
    .req_pc             (req_pc),
    .req_id             (req_id),
    .req_is_branch      (req_is_branch),
    .req_is_jump        (req_is_jump),
    .req_ready          (req_ready),
    .pred_valid         (pred_valid),
    .pred_taken         (pred_taken),
    .pred_pcnext        (pred_pcnext),
    .bq_push_valid      (bq_push_valid),
    .bq_push_ready      (bq_push_ready),
    .bq_push_bqid       (bq_push_bqid),
    .bq_push_pc         (bq_push_pc),
    .bq_push_id         (bq_push_id),
    .bq_push_bp         (bq_push_bp),
    .pred_bqid          (pred_bqid),
    .upd_valid          (upd_valid),
    .upd_pc             (upd_pc),
    .upd_taken          (upd_taken),
    .upd_target         (upd_target),
    .upd_missprediction (upd_missprediction),
    .squash_valid       (squash_valid),
    .perf_mispred_cnt   (perf_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; on return it sits in S1.
  task automatic send(input logic [63:0] pc, input logic br, input logic jmp, input logic [7:0] id);
    req_valid     = 1'b1;
    req_pc        = pc;
    req_is_branch = br;
    req_is_jump   = jmp;
    req_id        = id;
    cyc();
    req_valid     = 1'b0;
    req_is_jump   = 1'b0;
    #1;
  endtask

  task automatic update(input logic [63:0] pc, input logic tk, input logic [63:0] tgt, input logic mp);
    upd_valid          = 1'b1;
    upd_pc             = pc;
    upd_taken          = tk;
    upd_target         = tgt;
    upd_missprediction = mp;
    cyc();
    upd_valid          = 1'b0;
    upd_missprediction = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_pc = '0; req_id = '0;
    req_is_branch = 1'b0; req_is_jump = 1'b0; bq_push_ready = 1'b1;
    bq_push_bqid = 4'd3; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_missprediction = 1'b0; squash_valid = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_push_valid", bq_push_valid, 0);
    chk("rst_perf", perf_mispred_cnt, 0);

    // Cold branch: BTB empty -> not taken, fall through.
    send(64'h1000, 1, 0, 8'd5);
    chk("cold_pred_valid", pred_valid, 1);
    chk("cold_taken", pred_taken, 0);
    chk("cold_pcnext", pred_pcnext, 64'h1004);
    chk("cold_push_valid", bq_push_valid, 1);
    chk("cold_push_pc", bq_push_pc, 64'h1000);
    chk("cold_push_id", bq_push_id, 5);
    chk("cold_pred_bqid", pred_bqid, 3);
    cyc();
    chk("cold_drained", pred_valid, 0);

    // Train 0x1000: counter 01->10->11, BTB target 0x2000.
    update(64'h1000, 1, 64'h2000, 1);
    update(64'h1000, 1, 64'h2000, 1);
    #1;
    chk("perf_two", perf_mispred_cnt, 2);
    send(64'h1000, 1, 0, 8'd6);
    chk("trained_taken", pred_taken, 1);
    chk("trained_pcnext", pred_pcnext, 64'h2000);
    chk("trained_bp", bq_push_bp, {1'b1, 64'h2000});
    cyc();

    // Non-branch at a BTB-hit PC still falls through and never pushes.
    send(64'h1000, 0, 0, 8'd7);
    chk("nb_pred_valid", pred_valid, 1);
    chk("nb_taken", pred_taken, 0);
    chk("nb_pcnext", pred_pcnext, 64'h1004);
    chk("nb_push", bq_push_valid, 0);
    cyc();

    // 0x3010: counter 01->10->01; the not-taken update keeps the BTB entry.
    update(64'h3010, 1, 64'h4000, 0);
    update(64'h3010, 0, 64'h0, 0);
    send(64'h3010, 1, 0, 8'd8);
    chk("weak_cond_taken", pred_taken, 0);
    chk("weak_cond_pcnext", pred_pcnext, 64'h3014);
    cyc();
    send(64'h3010, 1, 1, 8'd8);
    chk("jump_taken", pred_taken, 1);
    chk("jump_pcnext", pred_pcnext, 64'h4000);
    cyc();

    // Same BTB/BHT index as 0x1000 but different tag -> miss.
    send(64'h11000, 1, 0, 8'd8);
    chk("tagmiss_taken", pred_taken, 0);
    chk("tagmiss_pcnext", pred_pcnext, 64'h11004);
    cyc();

    // Branch queue backpressure for three cycles.
    bq_push_ready = 1'b0;
    send(64'h1000, 1, 0, 8'd9);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      chk("bp_req_ready", req_ready, 0);
      chk("bp_pred_valid", pred_valid, 0);
      chk("bp_held_pc", bq_push_pc, 64'h1000);
    end
    bq_push_ready = 1'b1;
    #1;
    chk("bp_release_pred", pred_valid, 1);
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_pcnext", pred_pcnext, 64'h2000);
    chk("bp_release_id", bq_push_id, 9);
    cyc();
    chk("bp_single_push", bq_push_valid, 0);

    // Squash a held branch; a simultaneous update still trains (0x3010 01->10).
    bq_push_ready = 1'b0;
    send(64'h1000, 1, 0, 8'd10);
    cyc();
    squash_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h3010; upd_taken = 1'b1; upd_target = 64'h4000;
    #1;
    chk("sq_no_push", bq_push_valid, 0);
    chk("sq_no_pred", pred_valid, 0);
    chk("sq_req_ready", req_ready, 0);
    cyc();
    squash_valid = 1'b0;
    upd_valid = 1'b0;
    bq_push_ready = 1'b1;
    #1;
    chk("sq_after_pred", pred_valid, 0);
    chk("sq_after_push", bq_push_valid, 0);
    chk("sq_after_ready", req_ready, 1);

    // Lookup and not-taken update of 0x3010 in the same cycle: old counter (10).
    req_valid = 1'b1; req_pc = 64'h3010; req_is_branch = 1'b1; req_id = 8'd11;
    upd_valid = 1'b1; upd_pc = 64'h3010; upd_taken = 1'b0;
    cyc();
    req_valid = 1'b0;
    upd_valid = 1'b0;
    #1;
    chk("same_cyc_taken", pred_taken, 1);
    chk("same_cyc_pcnext", pred_pcnext, 64'h4000);
    cyc();
    send(64'h3010, 1, 0, 8'd12);
    chk("post_upd_taken", pred_taken, 0);
    chk("post_upd_pcnext", pred_pcnext, 64'h3014);
    cyc();

    // Reset while a branch is held under backpressure.
    bq_push_ready = 1'b0;
    send(64'h1000, 1, 0, 8'd13);
    chk("pre_rst_push", bq_push_valid, 1);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    bq_push_ready = 1'b1;
    #1;
    chk("midrst_push", bq_push_valid, 0);
    chk("midrst_pred", pred_valid, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_perf", perf_mispred_cnt, 0);
    send(64'h1000, 1, 0, 8'd14);
    chk("midrst_btb_clear", pred_pcnext, 64'h1004);
    cyc();

    // Misprediction counter saturation.
    force dut.perf_mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.perf_mispred_cnt;
    #1;
    chk("perf_preload", perf_mispred_cnt, 32'hFFFF_FFFE);
    update(64'h5000, 0, 64'h0, 1);
    #1;
    chk("perf_max", perf_mispred_cnt, 32'hFFFF_FFFF);
    update(64'h5000, 0, 64'h0, 1);
    #1;
    chk("perf_sat", perf_mispred_cnt, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
